// File: rtl/bg_pkg.sv
// Shared widths, band entry type, palette and VGA bus sizing for the band background painter.
package bg_pkg;

  localparam int DEF_CNT_W   = 12;
  localparam int DEF_COLOR_W = 12;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]   band_end;
    logic [DEF_COLOR_W-1:0] color;
  } band_t;

  // Sky / water / sand palette
  localparam logic [DEF_COLOR_W-1:0] SKY_HIGH   = 12'h3BE;
  localparam logic [DEF_COLOR_W-1:0] SKY_MID    = 12'h6CF;
  localparam logic [DEF_COLOR_W-1:0] SKY_HAZE   = 12'h7AD;
  localparam logic [DEF_COLOR_W-1:0] SKY_PALE   = 12'hBDF;
  localparam logic [DEF_COLOR_W-1:0] SEA_DEEP   = 12'h05A;
  localparam logic [DEF_COLOR_W-1:0] SEA_MID    = 12'h28D;
  localparam logic [DEF_COLOR_W-1:0] SEA_FOAM   = 12'h9CE;
  localparam logic [DEF_COLOR_W-1:0] CLOUD      = 12'hFFF;
  localparam logic [DEF_COLOR_W-1:0] SAND_DARK  = 12'h974;
  localparam logic [DEF_COLOR_W-1:0] SAND_MID   = 12'hC96;
  localparam logic [DEF_COLOR_W-1:0] SAND_LIGHT = 12'hEC9;
  localparam logic [DEF_COLOR_W-1:0] NET_GREY   = 12'h888;

  // Bus layout: {vcount, vsync, vblnk, hcount, hsync, hblnk, rgb}
  function automatic int vga_bus_size(input int cnt_w, input int color_w);
    return 2 * cnt_w + color_w + 4;
  endfunction

  localparam int VGA_BUS_SIZE = vga_bus_size(DEF_CNT_W, DEF_COLOR_W);

endpackage

// File: rtl/bg_band_table.sv
// Shadow/active band tables; the shadow is copied to the active table on a vblank rising edge
// when a commit is pending, so a visible frame always reads one consistent table.
module bg_band_table
  import bg_pkg::*;
#(
  parameter int                 N_BANDS       = 16,
  parameter int                 CNT_W         = DEF_CNT_W,
  parameter int                 COLOR_W       = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] DEFAULT_COLOR = SKY_HAZE,
  localparam int                IDX_W         = $clog2(N_BANDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [CNT_W-1:0]   wend,
  input  logic [COLOR_W-1:0] wcolor,
  input  logic               commit,
  input  logic               vblnk,
  output logic               pending,
  input  logic [IDX_W-1:0]   ridx,
  output logic [CNT_W-1:0]   rend,
  output logic [COLOR_W-1:0] rcolor
);

  logic [CNT_W-1:0]   shadow_end   [N_BANDS];
  logic [COLOR_W-1:0] shadow_color [N_BANDS];
  logic [CNT_W-1:0]   active_end   [N_BANDS];
  logic [COLOR_W-1:0] active_color [N_BANDS];
  logic               vblnk_prev;
  logic               copy;

  assign copy = vblnk && !vblnk_prev && pending;

  // The copy reads the shadow before any same-cycle write lands, so that write waits for the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BANDS; i++) begin
        shadow_end[i]   <= '1;
        shadow_color[i] <= (i == 0) ? DEFAULT_COLOR : '0;
        active_end[i]   <= '1;
        active_color[i] <= (i == 0) ? DEFAULT_COLOR : '0;
      end
      pending    <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk;
      if (copy) begin
        active_end   <= shadow_end;
        active_color <= shadow_color;
      end
      if (we) begin
        shadow_end[waddr]   <= wend;
        shadow_color[waddr] <= wcolor;
      end
      if (commit)
        pending <= 1'b1;
      else if (copy)
        pending <= 1'b0;
    end
  end

  assign rend   = active_end[ridx];
  assign rcolor = active_color[ridx];

endmodule

// File: rtl/draw_background_bands.sv
// Background painter: programmable vertical colour bands with an optional net rectangle.
// Two-stage pipeline; rgb is aligned with the timing signals delayed by two pixel clocks.
module draw_background_bands
  import bg_pkg::*;
#(
  parameter int                 N_BANDS       = 16,
  parameter int                 CNT_W         = DEF_CNT_W,
  parameter int                 COLOR_W       = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] DEFAULT_COLOR = SKY_HAZE,
  parameter int                 NET_X0        = 500,
  parameter int                 NET_X1        = 524,
  parameter int                 NET_Y0        = 450,
  parameter logic [COLOR_W-1:0] NET_COLOR     = NET_GREY,
  localparam int                IDX_W         = $clog2(N_BANDS)
) (
  input  logic                                       pclk,
  input  logic                                       rst_n,
  input  logic                                       cfg_we,
  input  logic [IDX_W-1:0]                           cfg_addr,
  input  logic [CNT_W-1:0]                           cfg_end,
  input  logic [COLOR_W-1:0]                         cfg_color,
  input  logic                                       cfg_commit,
  output logic                                       cfg_pending,
  input  logic                                       net_en,
  input  logic [CNT_W-1:0]                           hcount_in,
  input  logic                                       hsync_in,
  input  logic                                       hblnk_in,
  input  logic [CNT_W-1:0]                           vcount_in,
  input  logic                                       vsync_in,
  input  logic                                       vblnk_in,
  output logic [vga_bus_size(CNT_W, COLOR_W)-1:0]    vga_out
);

  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   band_end;
  logic [COLOR_W-1:0] band_color;

  bg_band_table #(
    .N_BANDS       (N_BANDS),
    .CNT_W         (CNT_W),
    .COLOR_W       (COLOR_W),
    .DEFAULT_COLOR (DEFAULT_COLOR)
  ) u_table (
    .clk     (pclk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wend    (cfg_end),
    .wcolor  (cfg_color),
    .commit  (cfg_commit),
    .vblnk   (vblnk_in),
    .pending (cfg_pending),
    .ridx    (idx),
    .rend    (band_end),
    .rcolor  (band_color)
  );

  // Stage 0 -> 1: band walker, at most one step per line, saturating at the last entry
  always_comb begin
    idx_nxt = idx;
    if (vcount_in == '0 && hcount_in == '0)
      idx_nxt = '0;
    else if (hcount_in == '0 && vcount_in > band_end && idx < IDX_W'(N_BANDS - 1))
      idx_nxt = idx + 1'b1;
  end

  logic               vld_p1;
  logic [CNT_W-1:0]   hcount_p1;
  logic [CNT_W-1:0]   vcount_p1;
  logic               hsync_p1;
  logic               hblnk_p1;
  logic               vsync_p1;
  logic               vblnk_p1;
  logic               net_en_p1;
  logic [COLOR_W-1:0] rgb_p1;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      vld_p1    <= 1'b0;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
      hsync_p1  <= 1'b0;
      hblnk_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      vblnk_p1  <= 1'b0;
      net_en_p1 <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      vld_p1    <= 1'b1;
      hcount_p1 <= hcount_in;
      vcount_p1 <= vcount_in;
      hsync_p1  <= hsync_in;
      hblnk_p1  <= hblnk_in;
      vsync_p1  <= vsync_in;
      vblnk_p1  <= vblnk_in;
      net_en_p1 <= net_en;
    end
  end

  // Stage 1 -> 2: colour select; the first pixel after reset stays black
  always_comb begin
    rgb_p1 = band_color;
    if (!vld_p1 || hblnk_p1 || vblnk_p1)
      rgb_p1 = '0;
    else if (net_en_p1 && int'(hcount_p1) > NET_X0 && int'(hcount_p1) <= NET_X1 &&
             int'(vcount_p1) > NET_Y0)
      rgb_p1 = NET_COLOR;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      vga_out <= '0;
    else
      vga_out <= {vcount_p1, vsync_p1, vblnk_p1, hcount_p1, hsync_p1, hblnk_p1, rgb_p1};
  end

endmodule
